// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction through fetch, decode,
// execute, memory and write-back, driving the shared-memory / shared-ALU datapath.
module multi_cycle_control #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  output logic             PC_w,
  output logic             PC_w_cond,
  output logic [1:0]       PC_src,
  output logic             IorD,
  output logic             Mem_r,
  output logic             Mem_w,
  output logic             IR_w,
  output logic             Mem_to_reg,
  output logic             Reg_dst,
  output logic             Reg_w,
  output logic             ALU_src_A,
  output logic [1:0]       ALU_src_B,
  output logic [1:0]       ALU_op,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned WAIT_W = 4;

  localparam logic [OP_W-1:0] OP_R     = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [OP_W-1:0]   r_op;
  logic [OP_W-1:0]   w_op_nxt;
  logic [CNT_W-1:0]  r_retired;
  logic [CNT_W-1:0]  w_retired_nxt;
  logic              r_run;
  logic              w_last;

  assign w_last = (r_wait == WAIT_LAST);

  // r_run holds the FSM idle until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_op      <= '0;
      r_retired <= '0;
    end else begin
      r_run     <= 1'b1;
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_op      <= w_op_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = '0;
    w_op_nxt      = r_op;
    w_retired_nxt = r_retired;
    PC_w          = 1'b0;
    PC_w_cond     = 1'b0;
    PC_src        = 2'b00;
    IorD          = 1'b0;
    Mem_r         = 1'b0;
    Mem_w         = 1'b0;
    IR_w          = 1'b0;
    Mem_to_reg    = 1'b0;
    Reg_dst       = 1'b0;
    Reg_w         = 1'b0;
    ALU_src_A     = 1'b0;
    ALU_src_B     = 2'b00;
    ALU_op        = 2'b00;

    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          Mem_r     = 1'b1;
          ALU_src_B = 2'b01;
          if (w_last) begin
            IR_w        = 1'b1;
            PC_w        = 1'b1;
            w_state_nxt = S_DECODE;
          end else begin
            w_wait_nxt = r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          ALU_src_B = 2'b11;
          w_op_nxt  = OpCode;
          case (OpCode)
            OP_R:             w_state_nxt = S_R_EXEC;
            OP_ADDIU, OP_ORI: w_state_nxt = S_I_EXEC;
            OP_LW, OP_SW:     w_state_nxt = S_MEM_ADDR;
            OP_BEQ:           w_state_nxt = S_BRANCH;
            OP_J:             w_state_nxt = S_JUMP;
            default:          w_state_nxt = S_ILLEGAL;
          endcase
        end
        S_MEM_ADDR: begin
          ALU_src_A   = 1'b1;
          ALU_src_B   = 2'b10;
          w_state_nxt = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          Mem_r = 1'b1;
          IorD  = 1'b1;
          if (w_last) w_state_nxt = S_MEM_WB;
          else        w_wait_nxt  = r_wait + WAIT_W'(1);
        end
        S_MEM_WB: begin
          Reg_w         = 1'b1;
          Mem_to_reg    = 1'b1;
          w_state_nxt   = S_FETCH;
          w_retired_nxt = r_retired + CNT_W'(1);
        end
        S_MEM_WR: begin
          Mem_w = 1'b1;
          IorD  = 1'b1;
          if (w_last) begin
            w_state_nxt   = S_FETCH;
            w_retired_nxt = r_retired + CNT_W'(1);
          end else begin
            w_wait_nxt = r_wait + WAIT_W'(1);
          end
        end
        S_R_EXEC: begin
          ALU_src_A   = 1'b1;
          ALU_op      = 2'b10;
          w_state_nxt = S_R_WB;
        end
        S_R_WB: begin
          Reg_w         = 1'b1;
          Reg_dst       = 1'b1;
          w_state_nxt   = S_FETCH;
          w_retired_nxt = r_retired + CNT_W'(1);
        end
        S_I_EXEC: begin
          ALU_src_A   = 1'b1;
          ALU_src_B   = 2'b10;
          ALU_op      = (r_op == OP_ORI) ? 2'b11 : 2'b00;
          w_state_nxt = S_I_WB;
        end
        S_I_WB: begin
          Reg_w         = 1'b1;
          w_state_nxt   = S_FETCH;
          w_retired_nxt = r_retired + CNT_W'(1);
        end
        S_BRANCH: begin
          ALU_src_A     = 1'b1;
          ALU_op        = 2'b01;
          PC_w_cond     = 1'b1;
          PC_src        = 2'b01;
          w_state_nxt   = S_FETCH;
          w_retired_nxt = r_retired + CNT_W'(1);
        end
        S_JUMP: begin
          PC_w          = 1'b1;
          PC_src        = 2'b10;
          w_state_nxt   = S_FETCH;
          w_retired_nxt = r_retired + CNT_W'(1);
        end
        S_ILLEGAL: w_state_nxt = S_ILLEGAL;
        default:   w_state_nxt = S_ILLEGAL;
      endcase
    end
  end

  assign State   = r_state;
  assign Illegal = (r_state == S_ILLEGAL);
  assign Retired = r_retired;

endmodule
